serial_master_port: RTL and testbench

- Master-side controller that turns one parallel host request (address, write data, direction) into a complete serial-bus transaction.
- Sequences bus request, address shift-out, ack wait, then write-data shift-out or read-data shift-in, including split suspend/resume.
- One instance sits between each host (CPU/UART bridge) and the m1_*/m2_* port group of the serial bus interconnect.

---
 rtl/serial_master_port.sv | 208 ++++++++++++++++++++
 tb/tb_serial_master_port.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_master_port.sv
// Master-side serial bus controller: one parallel host request becomes a full bus transaction.
// Optional ACK/read-data timeout is built when SERIAL_MASTER_PORT_TIMEOUT_EN is defined.
module serial_master_port #(
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned DATA_WIDTH  = 8
`ifdef SERIAL_MASTER_PORT_TIMEOUT_EN
    ,
    parameter int unsigned ACK_TIMEOUT = 64
`endif
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  m_breq,
    input  logic                  m_bgrant,
    input  logic                  m_split,
    input  logic                  m_ack,
    output logic                  m_mode,
    output logic                  m_wvalid,
    output logic                  m_wdata,
    input  logic                  m_rvalid,
    input  logic                  m_rdata
);

    localparam int unsigned MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int unsigned CW    = $clog2(MAX_W + 1);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] REQ      = 3'd1;
    localparam logic [2:0] ADDR     = 3'd2;
    localparam logic [2:0] ACK_WAIT = 3'd3;
    localparam logic [2:0] WDATA    = 3'd4;
    localparam logic [2:0] RDATA    = 3'd5;
    localparam logic [2:0] SPLIT    = 3'd6;
    localparam logic [2:0] DONE     = 3'd7;

    logic [2:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  write_q, write_d;
    logic                  err_c;

    logic                  req_ready_d, resp_valid_d, resp_err_d;
    logic [DATA_WIDTH-1:0] resp_rdata_d;
    logic                  m_breq_d, m_mode_d, m_wvalid_d, m_wdata_d;

`ifdef SERIAL_MASTER_PORT_TIMEOUT_EN
    localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);
    logic [TW-1:0] tmo_q, tmo_d;
`endif

    // Next-state, shift registers and registered-output values derived from the next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        write_d = write_q;
        err_c   = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    write_d = req_write;
                    rdata_d = '0;
                    cnt_d   = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (m_bgrant) begin
                    cnt_d   = '0;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (!m_bgrant) begin
                    err_c   = 1'b1;
                    state_d = DONE;
                end else if (cnt_q == CW'(ADDR_WIDTH - 1)) begin
                    cnt_d   = '0;
                    state_d = ACK_WAIT;
                end else begin
                    cnt_d  = cnt_q + CW'(1);
                    addr_d = addr_q >> 1;
                end
            end
            ACK_WAIT: begin
                if (m_ack) begin
                    cnt_d   = '0;
                    state_d = write_q ? WDATA : RDATA;
                end
            end
            WDATA: begin
                if (!m_bgrant) begin
                    err_c   = 1'b1;
                    state_d = DONE;
                end else if (cnt_q == CW'(DATA_WIDTH - 1)) begin
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    wdata_d = wdata_q >> 1;
                end
            end
            RDATA: begin
                // A split before the first bit takes priority over a coincident read strobe
                if (m_split && (cnt_q == '0)) begin
                    state_d = SPLIT;
                end else if (m_rvalid) begin
                    rdata_d = {m_rdata, rdata_q[DATA_WIDTH-1:1]};
                    if (cnt_q == CW'(DATA_WIDTH - 1)) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            SPLIT: begin
                if (!m_split && m_bgrant) begin
                    state_d = RDATA;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

`ifdef SERIAL_MASTER_PORT_TIMEOUT_EN
        tmo_d = '0;
        if ((state_d == state_q) && ((state_q == ACK_WAIT) || (state_q == RDATA))) begin
            if ((state_q == RDATA) && m_rvalid) begin
                tmo_d = '0;
            end else if (tmo_q == TW'(ACK_TIMEOUT - 1)) begin
                err_c   = 1'b1;
                state_d = DONE;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
`endif

        req_ready_d  = (state_d == IDLE);
        resp_valid_d = (state_d == DONE);
        resp_err_d   = (state_d == DONE) && err_c;
        resp_rdata_d = ((state_d == DONE) && !write_q) ? rdata_d : '0;
        m_breq_d     = (state_d != IDLE) && (state_d != DONE);
        m_mode_d     = m_breq_d && (state_d != REQ) && write_q;
        m_wvalid_d   = (state_d == ADDR) || (state_d == WDATA);
        m_wdata_d    = (state_d == ADDR)  ? addr_d[0]  :
                       (state_d == WDATA) ? wdata_d[0] : 1'b0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            write_q    <= 1'b0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            m_breq     <= 1'b0;
            m_mode     <= 1'b0;
            m_wvalid   <= 1'b0;
            m_wdata    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            write_q    <= write_d;
            req_ready  <= req_ready_d;
            resp_valid <= resp_valid_d;
            resp_err   <= resp_err_d;
            resp_rdata <= resp_rdata_d;
            m_breq     <= m_breq_d;
            m_mode     <= m_mode_d;
            m_wvalid   <= m_wvalid_d;
            m_wdata    <= m_wdata_d;
        end
    end

`ifdef SERIAL_MASTER_PORT_TIMEOUT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

endmodule

// File: tb/tb_serial_master_port.sv
// Scoreboard bench for serial_master_port: stimulus pushes expected responses, a monitor pops them.
// Serial-side bit streams and control outputs are checked inline by the stimulus process.
module tb_serial_master_port;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid, req_ready, req_write;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        resp_valid;
    logic [7:0]  resp_rdata;
    logic        resp_err;
    logic        m_breq, m_bgrant, m_split, m_ack, m_mode;
    logic        m_wvalid, m_wdata, m_rvalid, m_rdata;

    typedef struct packed {
        logic [7:0] rdata;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   vectors    = 0;
    int   miscompares = 0;
    int   cyc        = 0;
    int   acc_cyc    = 0;

    serial_master_port dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .m_breq     (m_breq),
        .m_bgrant   (m_bgrant),
        .m_split    (m_split),
        .m_ack      (m_ack),
        .m_mode     (m_mode),
        .m_wvalid   (m_wvalid),
        .m_wdata    (m_wdata),
        .m_rvalid   (m_rvalid),
        .m_rdata    (m_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: every response pulse must match the oldest expected entry
    always @(posedge clk) begin
        #1;
        if (resp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("resp_rdata", 32'(resp_rdata), 32'(e.rdata));
                chk("resp_err", 32'(resp_err), 32'(e.err));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic w, input logic [15:0] a, input logic [7:0] d);
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        step();
        acc_cyc   = cyc;
        req_valid = 1'b0;
        req_addr  = 16'hFFFF;
        req_wdata = 8'hFF;
    endtask

    // Checks nbits serial bits LSB first, one per cycle, starting with the bit now presented
    task automatic shift_check(input string nm, input logic [15:0] v, input int nbits, input logic mode);
        int bad = 0;
        for (int i = 0; i < nbits; i++) begin
            if (m_wvalid !== 1'b1 || m_wdata !== v[i] || m_mode !== mode || m_breq !== 1'b1) bad++;
            step();
        end
        chk(nm, 32'(bad), 32'd0);
    endtask

    task automatic do_read(input logic [15:0] a, input logic [7:0] d, input logic split);
        int bad = 0;
        issue(1'b0, a, d);
        exp_q.push_back('{rdata: d, err: 1'b0});
        step();
        shift_check("rd_addr_bits", a, 16, 1'b0);
        m_ack = 1'b1;
        step();
        m_ack = 1'b0;
        if (split) begin
            // split together with a junk read strobe: the strobe must be discarded
            m_split  = 1'b1;
            m_rvalid = 1'b1;
            m_rdata  = 1'b1;
            m_bgrant = 1'b0;
            step();
            m_rvalid = 1'b0;
            for (int i = 0; i < 19; i++) begin
                if (m_wvalid !== 1'b0 || m_breq !== 1'b1) bad++;
                if (i == 10) m_bgrant = 1'b1;
                step();
            end
            m_split = 1'b0;
            step();
        end
        for (int k = 0; k < 8; k++) begin
            if (m_wvalid !== 1'b0 || m_breq !== 1'b1) bad++;
            m_rvalid = 1'b1;
            m_rdata  = d[k];
            step();
            if (k == 3) begin
                m_rvalid = 1'b0;
                m_rdata  = 1'b1;
                step();
            end
        end
        m_rvalid = 1'b0;
        m_rdata  = 1'b0;
        chk("rd_no_addr_resend", 32'(bad), 32'd0);
        chk("rd_resp_valid", 32'(resp_valid), 32'd1);
        chk("rd_breq_done", 32'(m_breq), 32'd0);
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int bad;
        rstn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        m_bgrant = 1'b0; m_split = 1'b0; m_ack = 1'b0; m_rvalid = 1'b0; m_rdata = 1'b0;
        #12;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_breq", 32'(m_breq), 32'd0);
        chk("rst_wvalid", 32'(m_wvalid), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        step();
        rstn = 1'b1;
        m_bgrant = 1'b1;
        step();

        // Write 0x0A35 / 0xC3, ack in the third ACK_WAIT cycle
        issue(1'b1, 16'h0A35, 8'hC3);
        exp_q.push_back('{rdata: 8'h00, err: 1'b0});
        chk("wr_breq_req", 32'(m_breq), 32'd1);
        step();
        shift_check("wr_addr_bits", 16'h0A35, 16, 1'b1);
        chk("wr_ackwait_wvalid", 32'(m_wvalid), 32'd0);
        chk("wr_ackwait_mode", 32'(m_mode), 32'd1);
        chk("wr_ackwait_breq", 32'(m_breq), 32'd1);
        step();
        step();
        m_ack = 1'b1;
        step();
        m_ack = 1'b0;
        shift_check("wr_data_bits", 16'h00C3, 8, 1'b1);
        chk("wr_resp_valid", 32'(resp_valid), 32'd1);
        // accept cycle counted as cycle 1
        chk("wr_latency", 32'(cyc - acc_cyc + 1), 32'd29);
        step();

        do_read(16'h0123, 8'hA5, 1'b0);
        do_read(16'h0040, 8'h5A, 1'b1);

        // Grant loss while address bit 5 is on the wire
        issue(1'b1, 16'h1234, 8'hFF);
        exp_q.push_back('{rdata: 8'h00, err: 1'b1});
        step();
        for (int i = 0; i < 5; i++) step();
        chk("gl_bit5_wvalid", 32'(m_wvalid), 32'd1);
        chk("gl_bit5_wdata", 32'(m_wdata), 32'd1);
        m_bgrant = 1'b0;
        step();
        chk("gl_resp_valid", 32'(resp_valid), 32'd1);
        chk("gl_wvalid", 32'(m_wvalid), 32'd0);
        chk("gl_breq", 32'(m_breq), 32'd0);
        m_bgrant = 1'b1;
        step();

        // No ack after the address phase
        issue(1'b1, 16'h00F0, 8'h81);
        step();
        shift_check("to_addr_bits", 16'h00F0, 16, 1'b1);
`ifdef SERIAL_MASTER_PORT_TIMEOUT_EN
        exp_q.push_back('{rdata: 8'h00, err: 1'b1});
        n = 0;
        while (resp_valid !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        chk("to_cycles", 32'(n), 32'd64);
        step();
`else
        exp_q.push_back('{rdata: 8'h00, err: 1'b0});
        bad = 0;
        repeat (210) begin
            if (resp_valid !== 1'b0 || m_breq !== 1'b1 || m_wvalid !== 1'b0) bad++;
            step();
        end
        chk("noto_waits", 32'(bad), 32'd0);
        m_ack = 1'b1;
        step();
        m_ack = 1'b0;
        shift_check("noto_data_bits", 16'h0081, 8, 1'b1);
        chk("noto_resp_valid", 32'(resp_valid), 32'd1);
        step();
`endif

        // Reset during write data bit 3: no response may follow
        issue(1'b1, 16'h5555, 8'h3C);
        step();
        for (int i = 0; i < 16; i++) step();
        m_ack = 1'b1;
        step();
        m_ack = 1'b0;
        step(); step(); step();
        chk("rs_bit3_wvalid", 32'(m_wvalid), 32'd1);
        chk("rs_bit3_wdata", 32'(m_wdata), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk("rs_async_breq", 32'(m_breq), 32'd0);
        chk("rs_async_wvalid", 32'(m_wvalid), 32'd0);
        step();
        step();
        rstn = 1'b1;
        bad = 0;
        repeat (5) begin
            step();
            if (resp_valid !== 1'b0) bad++;
        end
        chk("rs_no_resp", 32'(bad), 32'd0);
        chk("rs_req_ready", 32'(req_ready), 32'd1);

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
